// File: rtl/regfile_dump_reader.sv
// Debug register-file dumper: halts the core, walks every register through one
// read port and streams (index, data) pairs out over a valid/ready interface.
module regfile_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [2:0]        dbg_state
);

  // Output handshake: a pair moves on a rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and idx/data stay frozen while valid
  // is high and not yet accepted.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_READ      = 3'd2,
    S_SEND      = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rf_addr_q  <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rf_addr_q  <= rf_addr_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rf_addr_d  = rf_addr_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    rf_addr    = rf_addr_q;
    halt_req   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    abort      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        halt_req = 1'b1;
        if (halt_ack) state_d = S_READ;
      end
      S_READ: begin
        halt_req  = 1'b1;
        rf_addr   = idx_q;
        rf_addr_d = idx_q;
        if (!halt_ack) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          out_idx_d  = idx_q;
          out_data_d = rf_data;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        halt_req = 1'b1;
        // Losing the freeze wins over a same-cycle handshake: the pair is dropped.
        if (!halt_ack) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_FINISH;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_READ;
            end
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: expected pairs queue per DUT, with a
// negedge monitor popping and comparing every accepted pair.
module tb_regfile_dump_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_HALT = 3'd1, ST_READ = 3'd2, ST_SEND = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_s = 1'b0;
  logic halt_ack = 1'b1;
  logic out_ready = 1'b1;

  logic              halt_req, out_valid, busy, done, abort;
  logic [ADDR_W-1:0] rf_addr, out_idx;
  logic [DATA_W-1:0] rf_data, out_data;
  logic [2:0]        dbg_state;

  logic              halt_req_s, out_valid_s, busy_s, done_s, abort_s;
  logic [ADDR_W-1:0] rf_addr_s, out_idx_s;
  logic [DATA_W-1:0] rf_data_s, out_data_s;
  logic [2:0]        dbg_state_s;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_s_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt = 0, done_cyc = 0, abort_cnt = 0;
  int done_cnt_s = 0, done_cyc_s = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rf_val(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : (32'hA500_0000 + 32'(a));
  endfunction

  assign rf_data   = rf_val(rf_addr);
  assign rf_data_s = rf_val(rf_addr_s);

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP_ZERO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done), .abort(abort),
    .dbg_state(dbg_state)
  );

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP_ZERO(1'b1)) u_dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start_s), .halt_req(halt_req_s), .halt_ack(halt_ack),
    .rf_addr(rf_addr_s), .rf_data(rf_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_idx(out_idx_s), .out_data(out_data_s), .busy(busy_s), .done(done_s), .abort(abort_s),
    .dbg_state(dbg_state_s)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: a pair is accepted on the coming posedge when valid && ready now.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pair", {out_idx, out_data}, '1);
      else check("pair", {out_idx, out_data}, exp_q.pop_front());
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (abort) abort_cnt++;
  end

  always @(negedge clk) begin
    if (out_valid_s && out_ready) begin
      if (exp_s_q.size() == 0) check("unexpected_pair_skip", {out_idx_s, out_data_s}, '1);
      else check("pair_skip", {out_idx_s, out_data_s}, exp_s_q.pop_front());
    end
    if (done_s) begin done_cnt_s++; done_cyc_s = cyc; end
  end

  task automatic push_range(input bit sel, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (sel) exp_s_q.push_back({ADDR_W'(i), rf_val(ADDR_W'(i))});
      else     exp_q.push_back({ADDR_W'(i), rf_val(ADDR_W'(i))});
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_s = 1'b1; else start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; start_s = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    int d0;
    d0 = sel ? done_cnt_s : done_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((sel ? done_cnt_s : done_cnt) != d0) break;
    end
    @(negedge clk);
    check(name, sel ? done_cnt_s : done_cnt, d0 + 1);
  endtask

  task automatic wait_read(input logic [ADDR_W-1:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = (dbg_state == ST_READ) && (rf_addr == a);
    end
    if (!hit) check("wait_read_timeout", 0, 1);
  endtask

  task automatic wait_send(input logic [ADDR_W-1:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = (dbg_state == ST_SEND) && (out_idx == a);
    end
    if (!hit) check("wait_send_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_halt_req"}, halt_req, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_abort"}, abort, 0);
    check({name, "_rf_addr"}, rf_addr, 0);
    check({name, "_out_idx"}, out_idx, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int d0, a0;
    logic [ADDR_W-1:0] addr_before;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Basic dump, no backpressure.
    push_range(0, 0, 31);
    pulse_start(0);
    wait_done(0, "basic_done_once");
    check("basic_latency", done_cyc - start_cyc, 66);
    check("basic_queue_empty", exp_q.size(), 0);
    check("basic_halt_req_after", halt_req, 0);
    check("basic_busy_after", busy, 0);

    // SKIP_ZERO instance.
    push_range(1, 1, 31);
    pulse_start(1);
    wait_done(1, "skip_done_once");
    check("skip_latency", done_cyc_s - start_cyc, 64);
    check("skip_queue_empty", exp_s_q.size(), 0);
    check("skip_halt_req_after", halt_req_s, 0);

    // Backpressure: 7 stalled SEND cycles on idx 5.
    push_range(0, 0, 31);
    pulse_start(0);
    wait_read(5);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_pair", {out_idx, out_data}, {5'd5, 32'hA500_0005});
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    wait_done(0, "bp_done_once");
    check("bp_latency", done_cyc - start_cyc, 73);
    check("bp_queue_empty", exp_q.size(), 0);

    // Delayed halt acknowledge.
    halt_ack = 1'b0;
    addr_before = rf_addr;
    push_range(0, 0, 31);
    pulse_start(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hw_halt_req", halt_req, 1);
      check("hw_busy", busy, 1);
      check("hw_rf_addr", rf_addr, addr_before);
    end
    @(posedge clk); #1 halt_ack = 1'b1;
    @(negedge clk);
    check("hw_still_waiting", dbg_state, ST_HALT);
    @(negedge clk);
    check("hw_first_read", dbg_state, ST_READ);
    check("hw_first_addr", rf_addr, 0);
    wait_done(0, "hw_done_once");
    check("hw_latency", done_cyc - start_cyc, 76);
    check("hw_queue_empty", exp_q.size(), 0);

    // Abort in SEND at idx 12 with out_ready high.
    push_range(0, 0, 11);
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start(0);
    wait_read(12);
    @(posedge clk); #1 halt_ack = 1'b0;
    @(negedge clk);
    check("ab_abort", abort, 1);
    check("ab_out_valid", out_valid, 0);
    @(posedge clk); #1 halt_ack = 1'b1;
    @(negedge clk);
    check("ab_abort_once", abort_cnt, a0 + 1);
    check("ab_abort_low", abort, 0);
    check("ab_state_idle", dbg_state, ST_IDLE);
    check("ab_halt_req", halt_req, 0);
    repeat (3) @(negedge clk);
    check("ab_no_done", done_cnt, d0);
    check("ab_queue_empty", exp_q.size(), 0);
    push_range(0, 0, 31);
    pulse_start(0);
    wait_done(0, "ab_restart_done");
    check("ab_restart_latency", done_cyc - start_cyc, 66);
    check("ab_restart_queue_empty", exp_q.size(), 0);

    // Ignored start while busy, then reset mid-dump at idx 20.
    push_range(0, 0, 19);
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start(0);
    wait_send(3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_send(19);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (4) @(negedge clk);
    check("midreset_state", dbg_state, ST_IDLE);
    check("midreset_no_done", done_cnt, d0);
    check("midreset_no_abort", abort_cnt, a0);
    check("midreset_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug reader for the register file; walks every architectural register through one regfile read port and streams (index, data) pairs out over a valid/ready interface.
- Sits between the debug/trace unit and the regfile's rs/rd read pair. The reader only reads the regfile and never writes it.
- Requests a pipeline halt before reading so that the dumped state is stable.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- SKIP_ZERO, 0, when 1 the dump starts at index 1 (r0 is hardwired to 0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle dump request; sampled only in IDLE.
- halt_req  output  1  pipeline freeze request to the core.
- halt_ack  input  1  core is frozen; must remain high for the whole dump.
- rf_addr  output  ADDR_W  drives the regfile read-address port.
- rf_data  input  DATA_W  combinational read data returned for rf_addr.
- out_valid  output  1  out_idx/out_data hold a valid pair.
- out_ready  input  1  consumer accepts the pair.
- out_idx  output  ADDR_W  register index of the current pair.
- out_data  output  DATA_W  register contents of the current pair.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last pair has been accepted.
- abort  output  1  one-cycle pulse when halt_ack is lost mid-dump.

Behaviour:
- Reset (rst_n low at posedge clk):
  - State = IDLE; index counter = 0.
  - halt_req, out_valid, busy, done, abort = 0; rf_addr = 0; out_idx = 0; out_data = 0.
  - Reset takes effect from any state, including mid-dump; no done or abort pulse is produced.
- State machine: IDLE, HALT_WAIT, READ, SEND, FINISH.
- IDLE:
  - busy = 0.
  - start = 1 loads the index with (SKIP_ZERO ? 1 : 0) and moves to HALT_WAIT.
  - start in any other state is ignored.
- HALT_WAIT:
  - halt_req = 1.
  - Stays until halt_ack = 1, then moves to READ the next cycle.
  - No timeout.
- READ (exactly 1 cycle):
  - rf_addr = index.
  - At the clock edge, out_data <= rf_data and out_idx <= index; next state SEND.
- SEND:
  - out_valid = 1; out_idx and out_data are held stable until the handshake.
  - Handshake = out_valid & out_ready at the clock edge.
  - On handshake with index == NUM_REGS-1, go to FINISH.
  - On handshake with any other index, increment the index and go to READ.
  - Without a handshake, stay in SEND. Backpressure can last any number of cycles.
  - out_valid drops in the cycle after the handshake.
- FINISH (1 cycle):
  - done = 1 and halt_req = 0 in this cycle; next state IDLE.
- rf_addr outside READ:
  - Holds the last value driven (0 after reset).
  - The regfile treats r0 as 0, so reads at address 0 are harmless.
- halt_req:
  - High in HALT_WAIT, READ and SEND.
  - Low in IDLE and FINISH.
- Abort:
  - Condition: halt_ack = 0 while in READ or SEND.
  - Effect: abort pulses for 1 cycle; out_valid drops immediately (combinational gating); state returns to IDLE and halt_req drops.
  - Takes priority over a handshake in the same cycle; that pair is treated as not transferred.
- Throughput and latency:
  - One pair per 2 cycles at best (READ + SEND with out_ready = 1).
  - Full dump with no backpressure and immediate ack: 1 (HALT_WAIT) + 2*N + 1 (FINISH) cycles after start, where N is the number of pairs.
- Width rules:
  - The index counter is ADDR_W bits and never wraps; the terminal compare is against NUM_REGS-1.
  - NUM_REGS must be ≤ 2^ADDR_W.
- Simultaneous events: start arriving in the same cycle as FINISH is ignored; a new dump requires start to be asserted in IDLE.

Test Plan:
- Basic dump:
  - Stimulus: preload r1..r31 with 0xA5000000+i; SKIP_ZERO=0; pulse start; halt_ack tied high; out_ready=1.
  - Required: 32 pairs idx 0..31; data 0, then 0xA5000001..0xA500001F; done pulse exactly 66 cycles after start; halt_req low afterwards.
- Skip zero:
  - Stimulus: same preload, SKIP_ZERO=1.
  - Required: first pair idx=1 data=0xA5000001; 31 pairs total; done at cycle 64.
- Backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles on idx=5, then release.
  - Required: out_valid stays high with idx=5 and data=0xA5000005 stable throughout; no duplicate pair and no skipped index; done is delayed by exactly 7 cycles.
- Halt handshake:
  - Stimulus: delay halt_ack by 10 cycles after start.
  - Required: halt_req high, busy=1, rf_addr unchanged during the wait; first READ occurs the cycle after halt_ack rises.
- Abort:
  - Stimulus: drop halt_ack while in SEND at idx=12, with out_ready=1 in the same cycle.
  - Required: abort pulses once, out_valid=0 that cycle, no done pulse, return to IDLE with halt_req=0; a following start restarts the dump from idx 0.
- Reset mid-dump and ignored start:
  - Stimulus: assert rst_n=0 at idx=20; pulse start while busy.
  - Required: after reset every output is 0 and there is no done or abort pulse; start while busy has no effect on the index or the pair sequence.
